key_priority_display: RTL and testbench

// - Parametrised successor to the cascaded 8-to-3 priority encoder / BCD 7-segment decoder front panel.
// - Takes N_CH active-low key lines and synchronises and debounces them.
// - Priority-encodes the result (highest index wins) into a registered code and raises a one-cycle strobe for each new key.
// - Drives a time-multiplexed 2-digit decimal 7-segment display of the code.
// - Sits between the board key pads and the display/segment pins; KeyCode/KeyStb feed downstream control logic.

---
 rtl/key_priority_display.sv | 172 +++++++++++++++++
 tb/tb_key_priority_display.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_priority_display.sv
// key_priority_display: debounced active-low key pad, highest-index priority
// encoder with a registered code and new-key strobe, and a two-digit decimal
// 7-segment display multiplexer for the current code.
//
// Output handshake: KeyStb is a one-cycle valid qualifier for KeyCode. There
// is no ready/backpressure; a consumer must capture KeyCode in the cycle
// KeyStb is high. KeyCode stays stable while GS is high and the same key wins.
module key_priority_display #(
    parameter int N_CH        = 16,
    parameter int DEB_DIV     = 50000,
    parameter int REFRESH_DIV = 25000,
    parameter bit LATCH       = 1'b1,
    localparam int CW         = $clog2(N_CH)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EI,
    input  logic [N_CH-1:0] DataIn,
    output logic [CW-1:0]   KeyCode,
    output logic            GS,
    output logic            KeyStb,
    output logic [7:0]      Seg,
    output logic [1:0]      Dig
);

    localparam int DBW = $clog2(DEB_DIV);
    localparam int RW  = $clog2(REFRESH_DIV);

    // Synchroniser and debounce state (all-ones = every key released)
    logic [N_CH-1:0] sync1, sync2;
    logic [N_CH-1:0] smp_a, smp_b;
    logic [N_CH-1:0] deb_vec;
    logic [N_CH-1:0] agree;
    logic [DBW-1:0]  deb_cnt;
    logic            deb_tick;

    // Encoder result
    logic [CW-1:0]   enc_code;
    logic            enc_any;

    // Output next-state
    logic            gs_nxt;
    logic            stb_nxt;
    logic [CW-1:0]   code_nxt;
    logic            disp_on;
    logic            disp_nxt;

    // Display
    logic [RW-1:0]   ref_cnt;
    logic            ref_tick;
    logic [1:0]      dig_nxt;
    logic [6:0]      code_ext;
    logic [3:0]      tens;
    logic [3:0]      ones;
    logic [7:0]      seg_nxt;

    // Segment pattern for one decimal digit, a..g on bits 0..6, dp off
    function automatic logic [7:0] seg_pat(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'h3F;
            4'd1:    p = 8'h06;
            4'd2:    p = 8'h5B;
            4'd3:    p = 8'h4F;
            4'd4:    p = 8'h66;
            4'd5:    p = 8'h6D;
            4'd6:    p = 8'h7D;
            4'd7:    p = 8'h07;
            4'd8:    p = 8'h7F;
            4'd9:    p = 8'h6F;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    assign deb_tick = (deb_cnt == DBW'(DEB_DIV - 1));
    // A channel may change only when the new sample matches both stored samples
    assign agree    = ~(sync2 ^ smp_a) & ~(sync2 ^ smp_b);

    // Synchronise key lines, run the sample timer and debounce per channel
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1   <= '1;
            sync2   <= '1;
            smp_a   <= '1;
            smp_b   <= '1;
            deb_vec <= '1;
            deb_cnt <= '0;
        end else begin
            sync1   <= DataIn;
            sync2   <= sync1;
            deb_cnt <= deb_tick ? '0 : deb_cnt + 1'b1;
            if (deb_tick) begin
                smp_a   <= sync2;
                smp_b   <= smp_a;
                deb_vec <= (deb_vec & ~agree) | (sync2 & agree);
            end
        end
    end

    // Priority encode: the highest pressed (low) index is the last one found
    always_comb begin
        enc_code = '0;
        enc_any  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!deb_vec[i]) begin
                enc_code = CW'(i);
                enc_any  = 1'b1;
            end
        end
    end

    // Decide next code, group-select, strobe and display enable
    always_comb begin
        gs_nxt   = 1'b0;
        stb_nxt  = 1'b0;
        code_nxt = KeyCode;
        disp_nxt = disp_on;
        if (EI) begin
            code_nxt = '0;
            disp_nxt = 1'b0;
        end else if (enc_any) begin
            gs_nxt   = 1'b1;
            code_nxt = enc_code;
            disp_nxt = 1'b1;
            stb_nxt  = !GS || (enc_code != KeyCode);
        end else if (!LATCH) begin
            code_nxt = '0;
            disp_nxt = 1'b0;
        end
    end

    assign ref_tick = (ref_cnt == RW'(REFRESH_DIV - 1));
    assign dig_nxt  = ref_tick ? {Dig[0], Dig[1]} : Dig;
    assign code_ext = 7'(code_nxt);
    assign tens     = 4'(code_ext / 7'd10);
    assign ones     = 4'(code_ext % 7'd10);

    // Pick the segment pattern for the digit that will be selected next cycle
    always_comb begin
        seg_nxt = 8'h00;
        if (disp_nxt) begin
            if (dig_nxt[0]) begin
                seg_nxt = seg_pat(ones);
            end else if (tens != 4'd0) begin
                seg_nxt = seg_pat(tens);
            end
        end
    end

    // Register encoder outputs, display enable and the multiplexed display
    always_ff @(posedge CLK) begin
        if (RST) begin
            KeyCode <= '0;
            GS      <= 1'b0;
            KeyStb  <= 1'b0;
            disp_on <= 1'b0;
            ref_cnt <= '0;
            Dig     <= 2'b01;
            Seg     <= 8'h00;
        end else begin
            KeyCode <= code_nxt;
            GS      <= gs_nxt;
            KeyStb  <= stb_nxt;
            disp_on <= disp_nxt;
            ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
            Dig     <= dig_nxt;
            Seg     <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_key_priority_display.sv
// Bench for key_priority_display: directed front-panel scenarios followed by
// random key/enable/reset traffic, checked every cycle against a behavioural
// model for both LATCH settings.
module tb_key_priority_display;

    localparam int N_CH = 16;
    localparam int DEB  = 4;
    localparam int REF  = 8;
    localparam int CW   = 4;
    localparam logic [N_CH-1:0] ALL1 = '1;

    // Clock/reset and stimulus
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ei  = 1'b0;
    logic [N_CH-1:0] din = '1;

    // DUT outputs, LATCH=1 and LATCH=0
    logic [CW-1:0] code1, code0;
    logic          gs1, gs0, stb1, stb0;
    logic [7:0]    seg1, seg0;
    logic [1:0]    dig1, dig0;

    always #5 clk = ~clk;

    key_priority_display #(.N_CH(N_CH), .DEB_DIV(DEB), .REFRESH_DIV(REF), .LATCH(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .EI(ei), .DataIn(din),
        .KeyCode(code1), .GS(gs1), .KeyStb(stb1), .Seg(seg1), .Dig(dig1)
    );

    key_priority_display #(.N_CH(N_CH), .DEB_DIV(DEB), .REFRESH_DIV(REF), .LATCH(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .EI(ei), .DataIn(din),
        .KeyCode(code0), .GS(gs0), .KeyStb(stb0), .Seg(seg0), .Dig(dig0)
    );

    // Counters and scoreboard
    int n_cmp = 0;
    int n_bad = 0;
    int phase_stb = 0;
    logic [CW-1:0] exp_q[$];

    // Behavioural model
    logic [7:0]      pat [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                   8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    logic [N_CH-1:0] din_q[$];
    logic [N_CH-1:0] smp_q[$];
    logic [N_CH-1:0] m_deb = '1;
    int              m_cyc = 0;
    bit              m_gs = 0, m_stb = 0, m_lat = 0;
    int              m_code1 = 0, m_code0 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_exp(input int code, input bit on, input logic [1:0] dig);
        if (!on) return 8'h00;
        if (dig == 2'b01) return pat[code % 10];
        if (code / 10 == 0) return 8'h00;
        return pat[code / 10];
    endfunction

    // Advance the model by one rising edge using the inputs present at that edge
    task automatic model_edge();
        logic [N_CH-1:0] smp;
        bit pressed;
        int code;
        if (rst) begin
            din_q.delete(); din_q.push_back(ALL1); din_q.push_back(ALL1);
            smp_q.delete(); smp_q.push_back(ALL1); smp_q.push_back(ALL1);
            m_deb = ALL1; m_cyc = 0;
            m_gs = 0; m_stb = 0; m_lat = 0; m_code1 = 0; m_code0 = 0;
            return;
        end
        // The key value seen by the debouncer is the one from two edges ago
        smp = din_q.pop_front();
        din_q.push_back(din);
        pressed = (m_deb != ALL1);
        code = 0;
        for (int i = 0; i < N_CH; i++) if (!m_deb[i]) code = i;
        if (ei) begin
            m_gs = 0; m_stb = 0; m_code1 = 0; m_code0 = 0; m_lat = 0;
        end else if (pressed) begin
            m_stb = !m_gs || (code != m_code1);
            m_gs = 1; m_code1 = code; m_code0 = code; m_lat = 1;
        end else begin
            m_gs = 0; m_stb = 0; m_code0 = 0;
        end
        if (m_stb) exp_q.push_back(CW'(m_code1));
        // Every DEB cycles a sample is taken; a key changes after three agreeing samples
        if ((m_cyc % DEB) == DEB - 1) begin
            for (int i = 0; i < N_CH; i++)
                if (smp[i] == smp_q[0][i] && smp[i] == smp_q[1][i]) m_deb[i] = smp[i];
            void'(smp_q.pop_front());
            smp_q.push_back(smp);
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        logic [1:0] dig_e;
        dig_e = ((m_cyc / REF) % 2 == 1) ? 2'b10 : 2'b01;
        check("code_l1", code1, m_code1);
        check("gs_l1",   gs1,   m_gs);
        check("stb_l1",  stb1,  m_stb);
        check("dig_l1",  dig1,  dig_e);
        check("seg_l1",  seg1,  seg_exp(m_code1, m_lat, dig_e));
        check("code_l0", code0, m_code0);
        check("gs_l0",   gs0,   m_gs);
        check("stb_l0",  stb0,  m_stb);
        check("dig_l0",  dig0,  dig_e);
        check("seg_l0",  seg0,  seg_exp(m_code0, m_gs, dig_e));
        if (stb1) begin
            phase_stb++;
            if (exp_q.size() == 0) check("stb_sb_extra", 1, 0);
            else check("stb_sb_code", code1, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_dig(input logic [1:0] d);
        int n;
        n = 0;
        while (dig1 !== d && n < 2 * REF + 2) begin
            step();
            n++;
        end
        if (dig1 !== d) check("dig_timeout", dig1, d);
    endtask

    initial begin
        int n;
        int k;

        // Reset
        rst = 1'b1;
        repeat (3) step();
        check("rst_code", code1, 0);
        check("rst_gs",   gs1,   0);
        check("rst_stb",  stb1,  0);
        check("rst_seg",  seg1,  8'h00);
        check("rst_dig",  dig1,  2'b01);
        rst = 1'b0;
        repeat (3) step();

        // Single key press
        phase_stb = 0;
        din = ALL1; din[3] = 1'b0;
        repeat (20) step();
        check("press_code", code1, 3);
        check("press_gs",   gs1,   1);
        check("press_nstb", phase_stb, 1);
        wait_dig(2'b01);
        check("press_ones", seg1, 8'h4F);
        wait_dig(2'b10);
        check("press_tens", seg1, 8'h00);

        // Higher index takes over
        phase_stb = 0;
        din[12] = 1'b0;
        repeat (20) step();
        check("prio_code", code1, 12);
        check("prio_nstb", phase_stb, 1);
        wait_dig(2'b10);
        check("prio_tens", seg1, 8'h06);
        wait_dig(2'b01);
        check("prio_ones", seg1, 8'h5B);

        // Bouncing lower-priority key
        phase_stb = 0;
        for (int t = 0; t < 60; t++) begin
            if (t % 3 == 0) din[5] = ~din[5];
            step();
        end
        din[5] = 1'b1;
        repeat (20) step();
        check("bounce_code", code1, 12);
        check("bounce_gs",   gs1,   1);
        check("bounce_nstb", phase_stb, 0);

        // Release everything
        phase_stb = 0;
        din = ALL1;
        repeat (20) step();
        check("rel_gs",    gs1,   0);
        check("rel_code1", code1, 12);
        check("rel_code0", code0, 0);
        check("rel_nstb",  phase_stb, 0);
        wait_dig(2'b01);
        check("rel_ones1", seg1, 8'h5B);
        check("rel_ones0", seg0, 8'h00);
        wait_dig(2'b10);
        check("rel_tens1", seg1, 8'h06);
        check("rel_tens0", seg0, 8'h00);

        // Enable blocks and re-validates a held key
        din = ALL1; din[7] = 1'b0;
        repeat (20) step();
        check("ei_pre_code", code1, 7);
        ei = 1'b1;
        step();
        check("ei_gs",   gs1,   0);
        check("ei_seg",  seg1,  8'h00);
        check("ei_code", code1, 0);
        repeat (5) step();
        ei = 1'b0;
        step();
        check("ei_back_stb",  stb1,  1);
        check("ei_back_code", code1, 7);

        // Reset in the middle of a debounce
        din = ALL1;
        repeat (20) step();
        din[9] = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (!stb1 && n < 40) begin
            step();
            n++;
        end
        check("rst_redeb_lat", (n >= 3 * DEB && n <= 3 * DEB + 3), 1);
        check("rst_redeb_code", code1, 9);

        // Random traffic
        for (int s = 0; s < 130; s++) begin
            k = $urandom_range(0, 19);
            if (k == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else if (k < 3) begin
                ei = ~ei;
            end else begin
                din = ALL1;
                repeat ($urandom_range(0, 2)) din[$urandom_range(0, N_CH - 1)] = 1'b0;
            end
            repeat ($urandom_range(1, 30)) step();
        end
        ei = 1'b0;
        din = ALL1;
        repeat (20) step();

        check("stb_sb_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
